// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared raster-timing definitions for the VGA timing generator.
//   - Default 640x480@60 geometry (800x525 total).
//   - calc_htotal / calc_vtotal: derive total line / frame length.
//   - axis_state_t: position of one axis within ACTIVE, FP, SYNC, BP.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SW_DEF     = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SW_DEF     = 2;
    localparam int V_BP_DEF     = 33;

    typedef enum logic [1:0] {
        AX_ACTIVE = 2'd0,
        AX_FP     = 2'd1,
        AX_SYNC   = 2'd2,
        AX_BP     = 2'd3
    } axis_state_t;

    function automatic int axis_total(input int size, input int fp, input int sw, input int bp);
        return size + fp + sw + bp;
    endfunction

    function automatic int calc_htotal(input int hsize, input int hfp, input int hsw, input int hbp);
        return axis_total(hsize, hfp, hsw, hbp);
    endfunction

    function automatic int calc_vtotal(input int vsize, input int vfp, input int vsw, input int vbp);
        return axis_total(vsize, vfp, vsw, vbp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One raster axis: a free-running counter 0..TOTAL-1 plus the region
//   (ACTIVE, FP, SYNC, BP) the counter currently sits in.
// Ports:
//   CLK      pixel clock
//   RESET    asynchronous active-low reset (count -> 0)
//   advance  step the counter this cycle
//   count    current position on the axis
//   state    region decoded from count
//   wrap     advance on the last position (count returns to 0 next edge)
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int  SIZE  = H_ACTIVE_DEF,
    parameter int  FP    = H_FP_DEF,
    parameter int  SW    = H_SW_DEF,
    parameter int  BP    = H_BP_DEF,
    localparam int TOTAL = axis_total(SIZE, FP, SW, BP),
    localparam int W     = $clog2(TOTAL)
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           advance,
    output logic [W-1:0]   count,
    output axis_state_t    state,
    output logic           wrap
);

    // Region boundaries; all lie below TOTAL, so they fit in W bits.
    localparam logic [W-1:0] ACT_END  = W'(SIZE);
    localparam logic [W-1:0] FP_END   = W'(SIZE + FP);
    localparam logic [W-1:0] SYNC_END = W'(SIZE + FP + SW);
    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);

    assign wrap = advance && (count == LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            count <= '0;
        else if (advance)
            count <= wrap ? '0 : count + W'(1);
    end

    always_comb begin
        state = AX_BP;
        if (count < ACT_END)
            state = AX_ACTIVE;
        else if (count < FP_END)
            state = AX_FP;
        else if (count < SYNC_END)
            state = AX_SYNC;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Free-running VGA raster timing generator. All outputs are registered
//   and reflect the raster position of the previous CE cycle.
//   Optional feature macro: VGA_TIMING_ADDR_EN adds the linear pixel
//   address output 'addr' (v*HSIZE+h, built incrementally).
// Ports:
//   CLK          pixel clock
//   RESET        asynchronous active-low reset
//   CE           pixel enable; everything holds while 0
//   Hsync/Vsync  active-low syncs
//   DE           active-pixel data enable
//   hpos/vpos    raster position (including blanking)
//   line_start   one-CE pulse at hpos==0
//   frame_start  one-CE pulse at hpos==0, vpos==0
//   addr         linear pixel address (VGA_TIMING_ADDR_EN only)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int  HSIZE  = H_ACTIVE_DEF,
    parameter int  HFP    = H_FP_DEF,
    parameter int  HSW    = H_SW_DEF,
    parameter int  HBP    = H_BP_DEF,
    parameter int  VSIZE  = V_ACTIVE_DEF,
    parameter int  VFP    = V_FP_DEF,
    parameter int  VSW    = V_SW_DEF,
    parameter int  VBP    = V_BP_DEF,
    localparam int HTOTAL = calc_htotal(HSIZE, HFP, HSW, HBP),
    localparam int VTOTAL = calc_vtotal(VSIZE, VFP, VSW, VBP),
    localparam int HW     = $clog2(HTOTAL),
    localparam int VW     = $clog2(VTOTAL)
`ifdef VGA_TIMING_ADDR_EN
    ,
    localparam int AW     = $clog2(HSIZE * VSIZE)
`endif
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CE,
    output logic          Hsync,
    output logic          Vsync,
    output logic          DE,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_ADDR_EN
    ,
    output logic [AW-1:0] addr
`endif
);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    axis_state_t   h_st, v_st;
    logic          h_wrap, v_wrap;
    logic          origin;
    logic          pix_act;

    vga_axis_counter #(.SIZE(HSIZE), .FP(HFP), .SW(HSW), .BP(HBP)) u_hcnt (
        .CLK     (CLK),
        .RESET   (RESET),
        .advance (CE),
        .count   (h),
        .state   (h_st),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(.SIZE(VSIZE), .FP(VFP), .SW(VSW), .BP(VBP)) u_vcnt (
        .CLK     (CLK),
        .RESET   (RESET),
        .advance (CE && h_wrap),
        .count   (v),
        .state   (v_st),
        .wrap    (v_wrap)
    );

    assign pix_act = (h_st == AX_ACTIVE) && (v_st == AX_ACTIVE);

    // origin is 1 exactly when (h,v) == (0,0): true out of reset, and
    // afterwards set only by the step that wraps the whole frame.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            origin <= 1'b1;
        else if (CE)
            origin <= v_wrap;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Hsync       <= 1'b1;
            Vsync       <= 1'b1;
            DE          <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (CE) begin
            Hsync       <= (h_st != AX_SYNC);
            Vsync       <= (v_st != AX_SYNC);
            DE          <= pix_act;
            hpos        <= h;
            vpos        <= v;
            line_start  <= (h == '0);
            frame_start <= origin;
        end else begin
            // Pulses last one CE cycle only, never stretched by CE gaps.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_ADDR_EN
    // addr_nxt holds the address the next active pixel will get; addr is
    // updated only on active pixels so it holds through blanking.
    logic [AW-1:0] addr_nxt;
    logic [AW-1:0] addr_cur;

    assign addr_cur = origin ? '0 : addr_nxt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            addr     <= '0;
            addr_nxt <= '0;
        end else if (CE && pix_act) begin
            addr     <= addr_cur;
            addr_nxt <= addr_cur + AW'(1);
        end
    end
`endif

endmodule
